lock_sequencer: RTL and testbench
=================================

Name: lock_sequencer

Overview:
Upstream controller for the canal lock datapath. It accepts one gondola transit request at a time and produces the lock's 7-bit command word: gondola arriving/departing, outer/inner port, increase/decrease water, and direction. It closes the loop on the lock's 4-bit status and its 8-bit water levels, so a full transit runs without switch input. A watchdog forces a safe state if the lock stops responding.

Parameters:
TOL, 1, max |lock_water - target| in water units counted as level-matched
DWELL, 10, cycles a port is held open after the lock reports it open
TIMEOUT, 255, max cycles allowed in any wait state before FAULT (8-bit counter)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req_valid  input  1  transit request
req_dir  input  1  1 = enter at outer side, exit inner; 0 = enter inner, exit outer
req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready
lock_water  input  8  current lock chamber level
outer_water  input  8  outer canal level
inner_water  input  8  inner canal level
lock_status  input  4  [0] arriving, [1] departing, [2] outer port closed, [3] inner port closed
lock_cmd  output  7  [0] arriving, [1] departing, [2] outer port (1=close), [3] inner port (1=close), [4] increase, [5] decrease, [6] direction
busy  output  1  high in any state except IDLE and FAULT
done  output  1  one-cycle pulse on transit completion
fault  output  1  sticky watchdog flag
state  output  4  current FSM state encoding, for debug

Behaviour:
- Reset (rst=0, async): state=IDLE; lock_cmd=7'b0001100 (both ports closed, no water, dir 0); busy=0; done=0; fault=0; counters=0. Reset mid-transit aborts immediately to these values.
- Acceptance: on req_valid & req_ready, latch req_dir into dir_r, then go to ALIGN_IN. Requests outside IDLE are ignored; there is no queue.
- Targets: entry = outer_water when dir_r=1, else inner_water. Exit is the opposite side. lock_cmd[6]=dir_r in all non-IDLE states.
- Match: |lock_water - target| <= TOL. Use 9-bit signed subtraction; no wrap.
- ALIGN_IN / ALIGN_OUT:
  - Both port bits are commanded closed.
  - lock_cmd[4]=1 when lock_water < target-TOL; lock_cmd[5]=1 when lock_water > target+TOL.
  - Water bits are combinational from state and lock_water, never both 1, and 0 unless lock_status[3:2]=2'b11.
  - Exit when matched.
- OPEN_IN: command the entry port open (bit 2 if dir_r=1, else bit 3 = 0). Wait for the matching lock_status bit = 0, then pulse lock_cmd[0] for one cycle and go to DWELL_IN.
- DWELL_IN: port stays open for DWELL cycles, then CLOSE_IN.
- CLOSE_IN: command the port closed and wait for lock_status[3:2]=2'b11, then ALIGN_OUT.
- OPEN_OUT / DWELL_OUT / CLOSE_OUT: same as the entry phase on the exit port, with a lock_cmd[1] pulse on open. After CLOSE_OUT: done=1 for one cycle, then IDLE.
- At most one port is ever commanded open. Port command bits are registered.
- Watchdog:
  - Counter clears on every state change and increments in ALIGN_*, OPEN_*, and CLOSE_*.
  - Reaching TIMEOUT goes to FAULT: both ports closed, water bits 0, fault=1, req_ready=0.
  - FAULT is left only by reset.
- DWELL counter saturates; DWELL=0 is treated as 1.
- A target already matched at ALIGN entry leaves ALIGN on the next cycle with no water command.

Test Plan:
- Reset with outer=73, inner=49, lock=52 -> lock_cmd=0001100, req_ready=1, busy=0, fault=0.
- req_dir=1 with lock model stepping +2/-1 -> lock_cmd[4] high while lock climbs 52..72; exits ALIGN_IN at 72; outer port opens; lock_cmd[0] one-cycle pulse; port held 10 cycles.
- Same transit continues -> outer port closes; lock_cmd[5] high while lock falls 72..50; inner port opens; lock_cmd[1] pulses; done pulse; back to IDLE with both ports closed.
- Lock status never reports the port open -> FAULT after 255 cycles, fault=1, lock_cmd=0001100; a new req_valid is ignored until reset.
- req_valid while busy, and a request with lock already at 49 and req_dir=0 -> busy request ignored; ALIGN_IN exits in 1 cycle with no water command.
- rst low during DWELL_OUT -> outputs reach reset values asynchronously; after release, accepts a new request.

Source files
------------

// File: rtl/lock_sequencer.sv
// Canal lock sequencer: runs one gondola transit at a time by closing the loop
// on the lock's port status and water levels, with a watchdog into a sticky FAULT.
module lock_sequencer #(
  parameter int unsigned TOL     = 1,
  parameter int unsigned DWELL   = 10,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_dir,
  output logic       req_ready,
  input  logic [7:0] lock_water,
  input  logic [7:0] outer_water,
  input  logic [7:0] inner_water,
  input  logic [3:0] lock_status,
  output logic [6:0] lock_cmd,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ALIGN_IN  = 4'd1,
    S_OPEN_IN   = 4'd2,
    S_DWELL_IN  = 4'd3,
    S_CLOSE_IN  = 4'd4,
    S_ALIGN_OUT = 4'd5,
    S_OPEN_OUT  = 4'd6,
    S_DWELL_OUT = 4'd7,
    S_CLOSE_OUT = 4'd8,
    S_FAULT     = 4'd9
  } state_t;

  // A zero dwell still holds the port open for one cycle.
  localparam logic [7:0]        DWELL_LAST = (DWELL == 0) ? 8'd0 : 8'(DWELL - 1);
  localparam logic [7:0]        WD_LAST    = 8'(TIMEOUT - 1);
  localparam logic signed [8:0] TOL_S      = 9'(TOL);

  state_t            state_q, state_d, state_nx_s;
  logic              dir_q, dir_d;
  logic [7:0]        wd_q, wd_d;
  logic [7:0]        dwell_q, dwell_d;
  logic [1:0]        port_q, port_d;
  logic              arr_q, arr_d, dep_q, dep_d, done_q, done_d;
  logic              busy_q, busy_d, ready_q, ready_d, fault_q, fault_d;
  logic              cdir_q, cdir_d;
  logic [7:0]        target_s;
  logic signed [8:0] diff_s;
  logic              low_s, high_s, matched_s, in_wait_s;
  logic              closed_both_s, entry_open_s, exit_open_s;
  logic              inc_s, dec_s;
  logic              unused_status_s;

  // Level to align against: exit side only while aligning for departure.
  always_comb begin
    target_s = 8'd0;
    if (state_q == S_ALIGN_OUT) begin
      target_s = dir_q ? inner_water : outer_water;
    end else begin
      target_s = dir_q ? outer_water : inner_water;
    end
  end

  assign diff_s          = $signed({1'b0, lock_water}) - $signed({1'b0, target_s});
  assign low_s           = (diff_s < -TOL_S);
  assign high_s          = (diff_s > TOL_S);
  assign matched_s       = !low_s && !high_s;
  assign closed_both_s   = (lock_status[3:2] == 2'b11);
  assign entry_open_s    = dir_q ? !lock_status[2] : !lock_status[3];
  assign exit_open_s     = dir_q ? !lock_status[3] : !lock_status[2];
  assign unused_status_s = ^lock_status[1:0];

  // Water commands follow lock_water directly and only with both ports sealed.
  always_comb begin
    inc_s = 1'b0;
    dec_s = 1'b0;
    if ((state_q == S_ALIGN_IN || state_q == S_ALIGN_OUT) && closed_both_s) begin
      inc_s = low_s;
      dec_s = high_s;
    end else begin
      inc_s = 1'b0;
      dec_s = 1'b0;
    end
  end

  // Transit sequencing; the watchdog overrides any wait state that stalls.
  always_comb begin
    state_nx_s = state_q;
    dir_d      = dir_q;
    in_wait_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_nx_s = S_ALIGN_IN;
          dir_d      = req_dir;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ALIGN_IN, S_ALIGN_OUT: begin
        in_wait_s = 1'b1;
        if (matched_s) begin
          state_nx_s = (state_q == S_ALIGN_IN) ? S_OPEN_IN : S_OPEN_OUT;
        end else begin
          state_nx_s = state_q;
        end
      end
      S_OPEN_IN: begin
        in_wait_s  = 1'b1;
        state_nx_s = entry_open_s ? S_DWELL_IN : S_OPEN_IN;
      end
      S_OPEN_OUT: begin
        in_wait_s  = 1'b1;
        state_nx_s = exit_open_s ? S_DWELL_OUT : S_OPEN_OUT;
      end
      S_DWELL_IN, S_DWELL_OUT: begin
        if (dwell_q >= DWELL_LAST) begin
          state_nx_s = (state_q == S_DWELL_IN) ? S_CLOSE_IN : S_CLOSE_OUT;
        end else begin
          state_nx_s = state_q;
        end
      end
      S_CLOSE_IN: begin
        in_wait_s  = 1'b1;
        state_nx_s = closed_both_s ? S_ALIGN_OUT : S_CLOSE_IN;
      end
      S_CLOSE_OUT: begin
        in_wait_s  = 1'b1;
        state_nx_s = closed_both_s ? S_IDLE : S_CLOSE_OUT;
      end
      S_FAULT: state_nx_s = S_FAULT;
      default: state_nx_s = S_FAULT;
    endcase
  end

  assign state_d = (in_wait_s && (state_nx_s == state_q) && (wd_q >= WD_LAST)) ? S_FAULT
                                                                               : state_nx_s;

  // Watchdog and dwell counters restart on every state change.
  always_comb begin
    wd_d    = 8'd0;
    dwell_d = 8'd0;
    port_d  = 2'b11;
    if (state_d != state_q) begin
      wd_d    = 8'd0;
      dwell_d = 8'd0;
    end else if (in_wait_s) begin
      wd_d    = wd_q + 8'd1;
      dwell_d = 8'd0;
    end else if (state_q == S_DWELL_IN || state_q == S_DWELL_OUT) begin
      wd_d    = 8'd0;
      dwell_d = (dwell_q == 8'hFF) ? dwell_q : dwell_q + 8'd1;
    end else begin
      wd_d    = 8'd0;
      dwell_d = 8'd0;
    end
    case (state_d)
      S_OPEN_IN, S_DWELL_IN:   port_d = dir_d ? 2'b10 : 2'b01;
      S_OPEN_OUT, S_DWELL_OUT: port_d = dir_d ? 2'b01 : 2'b10;
      default:                 port_d = 2'b11;
    endcase
  end

  assign arr_d   = (state_q == S_OPEN_IN)   && (state_d == S_DWELL_IN);
  assign dep_d   = (state_q == S_OPEN_OUT)  && (state_d == S_DWELL_OUT);
  assign done_d  = (state_q == S_CLOSE_OUT) && (state_d == S_IDLE);
  assign busy_d  = (state_d != S_IDLE) && (state_d != S_FAULT);
  assign ready_d = (state_d == S_IDLE);
  assign fault_d = (state_d == S_FAULT);
  assign cdir_d  = (state_d != S_IDLE) && dir_d;

  // State, counters and registered command outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      wd_q    <= 8'd0;
      dwell_q <= 8'd0;
      port_q  <= 2'b11;
      arr_q   <= 1'b0;
      dep_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      fault_q <= 1'b0;
      cdir_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      wd_q    <= wd_d;
      dwell_q <= dwell_d;
      port_q  <= port_d;
      arr_q   <= arr_d;
      dep_q   <= dep_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      fault_q <= fault_d;
      cdir_q  <= cdir_d;
    end
  end

  assign lock_cmd  = {cdir_q, dec_s, inc_s, port_q[1], port_q[0], dep_q, arr_q};
  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: a simple lock plant answers the commands, and each
// transit is judged against levels and timings derived from the transit rules.
module tb_lock_sequencer;

  localparam int TOL       = 1;
  localparam int DWELL     = 10;
  localparam int TIMEOUT   = 255;
  localparam int DWELL_EFF = (DWELL < 1) ? 1 : DWELL;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_dir = 1'b0;
  logic [7:0] lock_water = 8'd0;
  logic [7:0] outer_water = 8'd0;
  logic [7:0] inner_water = 8'd0;
  logic [3:0] lock_status = 4'b1100;
  logic       req_ready, busy, done, fault;
  logic [6:0] lock_cmd;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;
  int plant_lat = 1;
  bit stuck_inner = 1'b0;
  int cnt_o = 0;
  int cnt_i = 0;

  lock_sequencer #(.TOL(TOL), .DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir), .req_ready(req_ready),
    .lock_water(lock_water), .outer_water(outer_water), .inner_water(inner_water),
    .lock_status(lock_status), .lock_cmd(lock_cmd), .busy(busy), .done(done),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // One clock of the plant: water moves +2/-1, ports follow commands after plant_lat cycles.
  task automatic tick();
    logic [6:0] c;
    c = lock_cmd;
    @(posedge clk);
    #1;
    if (c[4] && !c[5]) lock_water = lock_water + 8'd2;
    else if (c[5] && !c[4]) lock_water = lock_water - 8'd1;
    if (lock_status[2] != c[2]) begin
      cnt_o++;
      if (cnt_o >= plant_lat) begin lock_status[2] = c[2]; cnt_o = 0; end
    end else cnt_o = 0;
    if ((lock_status[3] != c[3]) && !(stuck_inner && !c[3])) begin
      cnt_i++;
      if (cnt_i >= plant_lat) begin lock_status[3] = c[3]; cnt_i = 0; end
    end else cnt_i = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    outer_water = 8'd73; inner_water = 8'd49; lock_water = 8'd52; lock_status = 4'b1100;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (lock_cmd !== 7'b0001100) begin fails++; $display("FAIL reset_cmd: got %b exp 0001100", lock_cmd); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b exp 1", req_ready); end
    tests++; if ({busy, done, fault} !== 3'b000) begin fails++; $display("FAIL reset_flags: busy/done/fault got %b exp 000", {busy, done, fault}); end
    rst = 1'b1;
    tick();
    tests++; if (lock_cmd !== 7'b0001100 || req_ready !== 1'b1) begin fails++; $display("FAIL idle_hold: cmd %b ready %b exp 0001100/1", lock_cmd, req_ready); end
  endtask

  // Full transit; with abort set, reset is pulled three cycles into the exit dwell.
  task automatic do_transit(input logic d, input logic [7:0] o, input logic [7:0] i,
                            input logic [7:0] l, input bit abort);
    int tgt_in, tgt_out, lvl_in, lvl_out, tgt, ep, xp, phase, arr, dep, open_cnt, done_cnt;
    bit prev11, settled;
    outer_water = o; inner_water = i; lock_water = l;
    tgt_in = d ? int'(o) : int'(i);
    tgt_out = d ? int'(i) : int'(o);
    lvl_in = int'(l);
    while (lvl_in < tgt_in - TOL) lvl_in += 2;
    while (lvl_in > tgt_in + TOL) lvl_in -= 1;
    lvl_out = lvl_in;
    while (lvl_out < tgt_out - TOL) lvl_out += 2;
    while (lvl_out > tgt_out + TOL) lvl_out -= 1;
    ep = d ? 2 : 3;
    xp = d ? 3 : 2;
    phase = 0; arr = 0; dep = 0; open_cnt = 0; done_cnt = 0; prev11 = 1'b0; settled = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL pre_ready: got %b exp 1", req_ready); end
    req_dir = d; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 3000 && phase < 5; cyc++) begin
      if (phase == 0 && lock_cmd[ep] == 1'b0) begin
        phase = 1;
        tests++; if (int'(lock_water) != lvl_in) begin fails++; $display("FAIL entry_level: got %0d exp %0d", lock_water, lvl_in); end
      end
      if (phase == 1 && lock_cmd[ep] == 1'b1) begin
        phase = 2;
        tests++; if (arr != 1) begin fails++; $display("FAIL arrive_pulses: got %0d exp 1", arr); end
        tests++; if (open_cnt != DWELL_EFF) begin fails++; $display("FAIL entry_dwell: got %0d exp %0d", open_cnt, DWELL_EFF); end
      end
      if (phase == 2 && lock_cmd[xp] == 1'b0) begin
        phase = 3; open_cnt = 0;
        tests++; if (int'(lock_water) != lvl_out) begin fails++; $display("FAIL exit_level: got %0d exp %0d", lock_water, lvl_out); end
      end
      if (phase == 3 && lock_cmd[xp] == 1'b1) begin
        phase = 4;
        tests++; if (dep != 1) begin fails++; $display("FAIL depart_pulses: got %0d exp 1", dep); end
        tests++; if (open_cnt != DWELL_EFF) begin fails++; $display("FAIL exit_dwell: got %0d exp %0d", open_cnt, DWELL_EFF); end
      end
      if (phase == 2) begin
        settled = prev11 && (lock_status[3:2] == 2'b11);
        prev11 = (lock_status[3:2] == 2'b11);
      end
      if (phase == 4 && done_cnt > 0 && done == 1'b0) begin
        phase = 5;
        tests++; if (done_cnt != 1) begin fails++; $display("FAIL done_width: got %0d exp 1", done_cnt); end
        tests++; if (busy !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL end_idle: busy %b ready %b exp 0/1", busy, req_ready); end
        tests++; if (lock_cmd !== 7'b0001100) begin fails++; $display("FAIL end_cmd: got %b exp 0001100", lock_cmd); end
      end else begin
        tests++; if (lock_cmd[4] && lock_cmd[5]) begin fails++; $display("FAIL water_both: got %b", lock_cmd[5:4]); end
        tests++; if ((lock_cmd[4] || lock_cmd[5]) && (lock_status[3:2] != 2'b11 || lock_cmd[3:2] != 2'b11)) begin
          fails++; $display("FAIL water_gate: water %b status %b ports %b", lock_cmd[5:4], lock_status[3:2], lock_cmd[3:2]); end
        tests++; if (lock_cmd[3:2] === 2'b00) begin fails++; $display("FAIL both_open: got %b", lock_cmd[3:2]); end
        tests++; if (phase < 4 && done) begin fails++; $display("FAIL early_done: got 1 exp 0 in phase %0d", phase); end
        if (done) done_cnt++;
        if (done_cnt == 0) begin
          tests++; if (busy !== 1'b1 || lock_cmd[6] !== d) begin fails++; $display("FAIL busy_dir: busy %b dir %b exp 1/%b", busy, lock_cmd[6], d); end
        end
        if (phase == 0 || (phase == 2 && settled)) begin
          tgt = (phase == 0) ? tgt_in : tgt_out;
          tests++; if (lock_cmd[4] !== (int'(lock_water) < tgt - TOL)) begin fails++; $display("FAIL inc: got %b lock %0d tgt %0d", lock_cmd[4], lock_water, tgt); end
          tests++; if (lock_cmd[5] !== (int'(lock_water) > tgt + TOL)) begin fails++; $display("FAIL dec: got %b lock %0d tgt %0d", lock_cmd[5], lock_water, tgt); end
        end
      end
      arr += int'(lock_cmd[0]);
      dep += int'(lock_cmd[1]);
      if (phase == 1 && arr > 0 && !lock_cmd[ep]) open_cnt++;
      if (phase == 3 && dep > 0 && !lock_cmd[xp]) open_cnt++;
      if (abort && phase == 3 && open_cnt == 3) begin
        rst = 1'b0;
        #1;
        tests++; if (lock_cmd !== 7'b0001100) begin fails++; $display("FAIL abort_cmd: got %b exp 0001100", lock_cmd); end
        tests++; if ({busy, done, fault, req_ready} !== 4'b0001) begin fails++; $display("FAIL abort_flags: busy/done/fault/ready got %b exp 0001", {busy, done, fault, req_ready}); end
        lock_status = 4'b1100; cnt_o = 0; cnt_i = 0;
        @(negedge clk);
        rst = 1'b1;
        tick();
        return;
      end
      if (phase < 5) tick();
    end
    tests++; if (phase != 5) begin fails++; $display("FAIL transit_timeout: reached phase %0d exp 5", phase); end
  endtask

  task automatic test_transit();
    plant_lat = 2;
    do_transit(1'b1, 8'd73, 8'd49, 8'd52, 1'b0);
  endtask

  task automatic test_busy_ignored();
    bit seen;
    plant_lat = 1;
    outer_water = 8'd73; inner_water = 8'd49; lock_water = 8'd49;
    req_dir = 1'b0; req_valid = 1'b1;
    tick();
    req_dir = 1'b1;
    tests++; if (lock_cmd[5:4] !== 2'b00 || lock_cmd[3] !== 1'b1) begin fails++; $display("FAIL matched_align: water %b inner %b exp 00/1", lock_cmd[5:4], lock_cmd[3]); end
    tests++; if (busy !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL busy_state: busy %b ready %b exp 1/0", busy, req_ready); end
    tick();
    tests++; if (lock_cmd[3] !== 1'b0 || lock_cmd[2] !== 1'b1) begin fails++; $display("FAIL one_cycle_align: ports %b exp 01", lock_cmd[3:2]); end
    repeat (3) tick();
    tests++; if (lock_cmd[6] !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL busy_req_taken: dir %b busy %b exp 0/1", lock_cmd[6], busy); end
    req_valid = 1'b0;
    for (int k = 0; k < 600 && !done; k++) tick();
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL busy_done: got %b exp 1", done); end
    seen = 1'b0;
    repeat (20) begin tick(); if (busy || done) seen = 1'b1; end
    tests++; if (seen) begin fails++; $display("FAIL queued_req: got activity exp none"); end
  endtask

  task automatic test_random();
    logic d;
    logic [7:0] o, i, l;
    for (int t = 0; t < 5; t++) begin
      plant_lat = int'($urandom_range(3, 1));
      d = 1'($urandom_range(1, 0));
      o = 8'($urandom_range(200, 20));
      i = 8'($urandom_range(200, 20));
      l = 8'($urandom_range(200, 20));
      do_transit(d, o, i, l, 1'b0);
    end
  endtask

  task automatic test_fault();
    int n;
    plant_lat = 1; stuck_inner = 1'b1;
    outer_water = 8'd73; inner_water = 8'd49; lock_water = 8'd49;
    req_dir = 1'b0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 0;
    for (int k = 0; k < 400 && !fault; k++) begin
      if (!lock_cmd[3]) n++;
      tick();
    end
    tests++; if (fault !== 1'b1) begin fails++; $display("FAIL fault_flag: got %b exp 1", fault); end
    tests++; if (n != TIMEOUT) begin fails++; $display("FAIL fault_time: got %0d exp %0d", n, TIMEOUT); end
    tests++; if (lock_cmd !== 7'b0001100 || busy !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL fault_outputs: cmd %b busy %b ready %b exp 0001100/0/0", lock_cmd, busy, req_ready); end
    req_dir = 1'b1; req_valid = 1'b1;
    repeat (5) tick();
    req_valid = 1'b0;
    tests++; if (fault !== 1'b1 || busy !== 1'b0 || lock_cmd !== 7'b0001100) begin
      fails++; $display("FAIL fault_sticky: fault %b busy %b cmd %b exp 1/0/0001100", fault, busy, lock_cmd); end
    rst = 1'b0; stuck_inner = 1'b0; lock_status = 4'b1100; cnt_o = 0; cnt_i = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    tests++; if (fault !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL fault_clear: fault %b ready %b exp 0/1", fault, req_ready); end
  endtask

  task automatic test_reset_mid_transit();
    plant_lat = 1;
    do_transit(1'b1, 8'd73, 8'd49, 8'd52, 1'b1);
    do_transit(1'b0, 8'd120, 8'd60, 8'd90, 1'b0);
  endtask

  initial begin
    test_reset();
    test_transit();
    test_busy_ignored();
    test_random();
    test_fault();
    test_reset_mid_transit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
